// File: rtl/isched_pkg.sv
// Shared definitions for the intersection scheduler.
// Contents: the phase encoding (also driven onto the phase status port),
// the requester IDs used for alternating service, and the default
// durations in clock cycles.
package isched_pkg;

  // Code 7 is not a legal phase; the scheduler recovers from it via BLINK.
  typedef enum logic [2:0] {
    ALL_RED     = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    PED_WALK    = 3'd5,
    BLINK       = 3'd6
  } state_t;

  typedef enum logic {
    SIDE = 1'b0,
    PED  = 1'b1
  } req_t;

  localparam int DEF_MIN_MG     = 1500;
  localparam int DEF_MY_TIME    = 500;
  localparam int DEF_SG_TIME    = 1500;
  localparam int DEF_SY_TIME    = 500;
  localparam int DEF_WALK_TIME  = 1000;
  localparam int DEF_AR_TIME    = 200;
  localparam int DEF_BLINK_HALF = 250;
  localparam int DEF_FLASH_TIME = 300;
  localparam int DEF_TW         = 16;

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter that times each scheduler phase.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (count -> RST_VAL)
//   load, load_val    load load_val this cycle (takes priority)
//   hold              when high the count saturates at zero instead of wrapping
//   done              count == 0
//   count             current value (only present when PED_FLASH_EN is defined,
//                     where the walk-flash window needs it)
module phase_timer
  import isched_pkg::*;
#(
  parameter int            TW      = DEF_TW,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          hold,
  output logic          done
`ifdef PED_FLASH_EN
  ,
  output logic [TW-1:0] count
`endif
);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= RST_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0 || !hold) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

`ifdef PED_FLASH_EN
  assign count = count_reg;
`endif

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-actuated phase scheduler for a two-road intersection with a
// pedestrian crossing. Main road rests in green; side-road and pedestrian
// demand is latched and served (alternating when both wait) through yellow
// and all-red clearance. Emergency preempt favours the main road; fault
// forces flashing yellow.
// Ports:
//   clk_50, reset_n                   clock, asynchronous active-low reset
//   side_req, ped_req, emg_req, fault detector, button, preempt, fault inputs
//   main_R/G/Y, side_R/G/Y, walk      lamp drivers
//   ped_ack                           pedestrian request pending indicator
//   phase                             current phase code (isched_pkg::state_t)
// Optional build macro: PED_FLASH_EN -- walk flashes during the last
// FLASH_TIME cycles of PED_WALK; otherwise walk is steady.
module intersection_scheduler
  import isched_pkg::*;
#(
  parameter int MIN_MG     = DEF_MIN_MG,
  parameter int MY_TIME    = DEF_MY_TIME,
  parameter int SG_TIME    = DEF_SG_TIME,
  parameter int SY_TIME    = DEF_SY_TIME,
  parameter int WALK_TIME  = DEF_WALK_TIME,
  parameter int AR_TIME    = DEF_AR_TIME,
  parameter int BLINK_HALF = DEF_BLINK_HALF,
  parameter int TW         = DEF_TW,
  parameter int FLASH_TIME = DEF_FLASH_TIME
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emg_req,
  input  logic       fault,
  output logic       main_R,
  output logic       main_G,
  output logic       main_Y,
  output logic       side_R,
  output logic       side_G,
  output logic       side_Y,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  // Timer load values: a phase of N cycles loads N-1.
  localparam logic [TW-1:0] LV_MG = TW'(MIN_MG - 1);
  localparam logic [TW-1:0] LV_MY = TW'(MY_TIME - 1);
  localparam logic [TW-1:0] LV_SG = TW'(SG_TIME - 1);
  localparam logic [TW-1:0] LV_SY = TW'(SY_TIME - 1);
  localparam logic [TW-1:0] LV_PW = TW'(WALK_TIME - 1);
  localparam logic [TW-1:0] LV_AR = TW'(AR_TIME - 1);
  localparam logic [TW-1:0] LV_BH = TW'(BLINK_HALF - 1);

  state_t        state, state_next;
  state_t        target, target_next;
  req_t          last_served, last_next;
  logic          side_pend, side_pend_next;
  logic          ped_pend, ped_pend_next;
  logic          blink_on, blink_next;
  logic          pick_ped;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  logic          walk_lvl;

`ifdef PED_FLASH_EN
  logic [TW-1:0] timer_count;
  logic [TW-1:0] flash_cnt;
  logic          flash_on;
  logic          flash_win;
`endif

  phase_timer #(
    .TW     (TW),
    .RST_VAL(LV_AR)
  ) u_timer (
    .clk     (clk_50),
    .rst_n   (reset_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .hold    (state == MAIN_GREEN),
    .done    (tmr_done)
`ifdef PED_FLASH_EN
    ,
    .count   (timer_count)
`endif
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ALL_RED;
      target      <= MAIN_GREEN;
      last_served <= SIDE;
      side_pend   <= 1'b0;
      ped_pend    <= 1'b0;
      blink_on    <= 1'b0;
    end else begin
      state       <= state_next;
      target      <= target_next;
      last_served <= last_next;
      side_pend   <= side_pend_next;
      ped_pend    <= ped_pend_next;
      blink_on    <= blink_next;
    end
  end

  always_comb begin
    state_next  = state;
    target_next = target;
    last_next   = last_served;
    blink_next  = blink_on;
    pick_ped    = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = LV_AR;

    if (fault) begin
      if (state != BLINK) begin
        state_next = BLINK;
      end else if (tmr_done) begin
        blink_next = ~blink_on;
        tmr_load   = 1'b1;
        tmr_val    = LV_BH;
      end
    end else begin
      case (state)
        ALL_RED: if (tmr_done) state_next = emg_req ? MAIN_GREEN : target;
        MAIN_GREEN: if (tmr_done && (side_pend || ped_pend) && !emg_req) state_next = MAIN_YELLOW;
        MAIN_YELLOW: if (tmr_done) begin
          // Decide now what follows the clearance interval.
          state_next  = ALL_RED;
          target_next = MAIN_GREEN;
          if (!emg_req && (side_pend || ped_pend)) begin
            pick_ped    = (side_pend && ped_pend) ? (last_served == SIDE) : ped_pend;
            target_next = pick_ped ? PED_WALK : SIDE_GREEN;
            last_next   = pick_ped ? PED : SIDE;
          end
        end
        SIDE_GREEN: if (emg_req || tmr_done) state_next = SIDE_YELLOW;
        SIDE_YELLOW: if (tmr_done) begin
          state_next  = ALL_RED;
          target_next = MAIN_GREEN;
        end
        PED_WALK: if (emg_req || tmr_done) begin
          state_next  = ALL_RED;
          target_next = MAIN_GREEN;
        end
        BLINK: begin
          state_next  = ALL_RED;
          target_next = MAIN_GREEN;
          blink_next  = 1'b0;
        end
        default: state_next = BLINK;
      endcase
    end

    // Any phase change loads the duration of the phase being entered.
    if (state_next != state) begin
      tmr_load = 1'b1;
      case (state_next)
        MAIN_GREEN:  tmr_val = LV_MG;
        MAIN_YELLOW: tmr_val = LV_MY;
        SIDE_GREEN:  tmr_val = LV_SG;
        SIDE_YELLOW: tmr_val = LV_SY;
        PED_WALK:    tmr_val = LV_PW;
        BLINK:       tmr_val = LV_BH;
        default:     tmr_val = LV_AR;
      endcase
    end

    // Requests latch every cycle; entering the serving phase clears them,
    // and that clear beats a request arriving on the same cycle.
    side_pend_next = side_pend | side_req;
    ped_pend_next  = ped_pend | (ped_req && state != PED_WALK);
    if (state_next == SIDE_GREEN && state != SIDE_GREEN) side_pend_next = 1'b0;
    if (state_next == PED_WALK && state != PED_WALK) ped_pend_next = 1'b0;
  end

`ifdef PED_FLASH_EN
  assign flash_win = (state == PED_WALK) && (int'(timer_count) < FLASH_TIME);

  // Outside the flash window the toggle is parked at "on" with a full
  // half-period, so the first flash cycle shows walk lit.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt <= LV_BH;
      flash_on  <= 1'b1;
    end else if (!flash_win) begin
      flash_cnt <= LV_BH;
      flash_on  <= 1'b1;
    end else if (flash_cnt == '0) begin
      flash_cnt <= LV_BH;
      flash_on  <= ~flash_on;
    end else begin
      flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign walk_lvl = flash_win ? flash_on : 1'b1;
`else
  assign walk_lvl = 1'b1;
`endif

  always_comb begin
    main_R = 1'b0;
    main_G = 1'b0;
    main_Y = 1'b0;
    side_R = 1'b0;
    side_G = 1'b0;
    side_Y = 1'b0;
    walk   = 1'b0;
    case (state)
      ALL_RED:     begin main_R = 1'b1; side_R = 1'b1; end
      MAIN_GREEN:  begin main_G = 1'b1; side_R = 1'b1; end
      MAIN_YELLOW: begin main_Y = 1'b1; side_R = 1'b1; end
      SIDE_GREEN:  begin main_R = 1'b1; side_G = 1'b1; end
      SIDE_YELLOW: begin main_R = 1'b1; side_Y = 1'b1; end
      PED_WALK:    begin main_R = 1'b1; side_R = 1'b1; walk = walk_lvl; end
      BLINK:       begin main_Y = blink_on; side_Y = blink_on; end
      default:     ;
    endcase
  end

  assign ped_ack = ped_pend;
  assign phase   = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: directed scenarios plus
// randomized request/preempt/fault traffic, compared every cycle against a
// phase-age reference model.
module tb_intersection_scheduler;

  localparam int MIN_MG = 20, MY = 5, AR = 3, SG = 15, SY = 5, WALK = 12, BH = 4;
  localparam int P_AR = 0, P_MG = 1, P_MY = 2, P_SG = 3, P_SY = 4, P_PW = 5, P_BL = 6;
  localparam int R_SIDE = 0, R_PED = 1;

  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       side_req = 1'b0, ped_req = 1'b0, emg_req = 1'b0, fault = 1'b0;
  logic       main_R, main_G, main_Y, side_R, side_G, side_Y, walk, ped_ack;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #10 clk_50 = ~clk_50;

  intersection_scheduler #(
    .MIN_MG(MIN_MG), .MY_TIME(MY), .SG_TIME(SG), .SY_TIME(SY),
    .WALK_TIME(WALK), .AR_TIME(AR), .BLINK_HALF(BH)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n),
    .side_req(side_req), .ped_req(ped_req), .emg_req(emg_req), .fault(fault),
    .main_R(main_R), .main_G(main_G), .main_Y(main_Y),
    .side_R(side_R), .side_G(side_G), .side_Y(side_Y),
    .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  // Reference model: current phase, cycles already spent in it, and the
  // scheduler's bookkeeping, advanced by the rules of each phase.
  int m_phase, m_age, m_target, m_last;
  bit m_side, m_ped, m_blink;

  function automatic int dur(input int p);
    case (p)
      P_AR:    return AR;
      P_MG:    return MIN_MG;
      P_MY:    return MY;
      P_SG:    return SG;
      P_SY:    return SY;
      P_PW:    return WALK;
      default: return BH;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_AR; m_age = 0; m_target = P_MG; m_last = R_SIDE;
    m_side = 0; m_ped = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit e, input bit f);
    int np;
    bit expired, side_n, ped_n, restart;
    np      = m_phase;
    restart = 0;
    expired = (m_age >= dur(m_phase) - 1);
    side_n  = m_side | s;
    ped_n   = m_ped | (p && m_phase != P_PW);
    if (f) begin
      if (m_phase != P_BL) np = P_BL;
      else if (expired) begin m_blink = !m_blink; restart = 1; end
    end else begin
      case (m_phase)
        P_AR: if (expired) np = e ? P_MG : m_target;
        P_MG: if (expired && (m_side || m_ped) && !e) np = P_MY;
        P_MY: if (expired) begin
          np = P_AR;
          m_target = P_MG;
          if (!e) begin
            if (m_side && m_ped) begin
              m_last   = (m_last == R_SIDE) ? R_PED : R_SIDE;
              m_target = (m_last == R_PED) ? P_PW : P_SG;
            end else if (m_side) begin
              m_last = R_SIDE; m_target = P_SG;
            end else if (m_ped) begin
              m_last = R_PED; m_target = P_PW;
            end
          end
        end
        P_SG: if (e || expired) np = P_SY;
        P_SY: if (expired) begin np = P_AR; m_target = P_MG; end
        P_PW: if (e || expired) begin np = P_AR; m_target = P_MG; end
        default: begin np = P_AR; m_target = P_MG; m_blink = 0; end
      endcase
    end
    if (np == P_SG && m_phase != P_SG) side_n = 0;
    if (np == P_PW && m_phase != P_PW) ped_n = 0;
    if (np != m_phase || restart) m_age = 0;
    else if (m_age < 1000000) m_age++;
    m_phase = np;
    m_side  = side_n;
    m_ped   = ped_n;
  endtask

  function automatic logic [10:0] model_vec();
    logic mr, mg, my, sr, sg, sy, w;
    logic [2:0] ph;
    mr = 0; mg = 0; my = 0; sr = 0; sg = 0; sy = 0; w = 0;
    ph = 3'(m_phase);
    case (m_phase)
      P_AR: begin mr = 1; sr = 1; end
      P_MG: begin mg = 1; sr = 1; end
      P_MY: begin my = 1; sr = 1; end
      P_SG: begin mr = 1; sg = 1; end
      P_SY: begin mr = 1; sy = 1; end
      P_PW: begin mr = 1; sr = 1; w = 1; end
      default: begin my = m_blink; sy = m_blink; end
    endcase
    return {mr, mg, my, sr, sg, sy, w, m_ped, ph};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {main_R, main_G, main_Y, side_R, side_G, side_Y, walk, ped_ack, phase};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
      if (n_fail >= 25) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  endtask

  // One clock: drive at the falling edge, model on the rising edge,
  // compare at the next falling edge.
  task automatic run_cycle(input bit s, input bit p, input bit e, input bit f);
    side_req = s; ped_req = p; emg_req = e; fault = f;
    @(posedge clk_50);
    model_step(s, p, e, f);
    @(negedge clk_50);
    cyc++;
    check_val($sformatf("out c%0d", cyc), {21'd0, dut_vec()}, {21'd0, model_vec()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0);
  endtask

  task automatic wait_phase(input int p, input int age, input int max_c, input bit e, input string tag);
    int n;
    n = 0;
    while (!(m_phase == p && m_age == age) && n < max_c) begin
      run_cycle(0, 0, e, 0);
      n++;
    end
    check_val(tag, {31'd0, (m_phase == p && m_age == age)}, 32'd1);
  endtask

  initial begin
    bit s, p, e_lvl, f_lvl;
    model_reset();
    repeat (2) @(negedge clk_50);
    check_val("reset", {21'd0, dut_vec()}, {21'd0, model_vec()});
    reset_n = 1'b1;

    // Idle: 3 cycles all-red, then main green rests.
    idle(203);

    // Side demand during main green.
    idle(0);
    run_cycle(1, 0, 0, 0);
    idle(70);

    // Side and pedestrian together: pedestrian first, then side.
    run_cycle(1, 1, 0, 0);
    idle(110);

    // Preempt on the 4th cycle of side green, held with side demand pending.
    run_cycle(1, 0, 0, 0);
    wait_phase(P_SG, 3, 60, 0, "reach_sg4");
    run_cycle(0, 0, 1, 0);
    for (int i = 0; i < 45; i++) run_cycle(i == 20, 0, 1, 0);
    idle(60);

    // Fault during pedestrian walk, release, then fault again and reset.
    run_cycle(0, 1, 0, 0);
    wait_phase(P_PW, 5, 80, 0, "reach_pw6");
    for (int i = 0; i < 30; i++) run_cycle(i == 7, i == 11, 0, 1);
    idle(30);
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 1);
    #3 reset_n = 1'b0;
    #1 model_reset();
    check_val("async_rst", {21'd0, dut_vec()}, {21'd0, model_vec()});
    side_req = 0; ped_req = 0; emg_req = 0; fault = 0;
    @(negedge clk_50);
    check_val("rst_hold", {21'd0, dut_vec()}, {21'd0, model_vec()});
    reset_n = 1'b1;
    idle(10);

    // Randomized traffic.
    e_lvl = 0;
    f_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 99) < 6);
      p = ($urandom_range(0, 99) < 4);
      if (e_lvl) e_lvl = ($urandom_range(0, 99) >= 4);
      else       e_lvl = ($urandom_range(0, 999) < 15);
      if (f_lvl) f_lvl = ($urandom_range(0, 99) >= 5);
      else       f_lvl = ($urandom_range(0, 999) < 5);
      run_cycle(s, p, e_lvl, f_lvl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
